// File: rtl/alu_uart_interface.sv
// ============================================================================
// Module   : alu_uart_interface
// Brief    : Collects A/B/opcode bytes from UART RX, runs the ALU, sends result
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_uart_interface #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int NB_TIMEOUT = 24,
  parameter int TIMEOUT    = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam logic [NB_TIMEOUT-1:0] c_timeout_last = NB_TIMEOUT'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [NB_TIMEOUT-1:0] r_cnt;
  logic [NB_DATA-1:0]    r_data_a;
  logic [NB_DATA-1:0]    r_data_b;
  logic [NB_OP-1:0]      r_operation;
  logic [NB_DATA-1:0]    r_tx_data;
  logic                  r_tx_start;
  logic                  r_timeout;
  logic                  w_waiting;
  logic                  w_expire;

  // A byte arriving on the expiring cycle wins over the timeout.
  assign w_waiting = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_expire  = w_waiting && !i_rx_done && (r_cnt == c_timeout_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_done) w_next_state = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (i_rx_done)     w_next_state = ST_WAIT_OP;
        else if (w_expire) w_next_state = ST_IDLE;
      end
      ST_WAIT_OP: begin
        if (i_rx_done)     w_next_state = ST_EXEC;
        else if (w_expire) w_next_state = ST_IDLE;
      end
      ST_EXEC: begin
        w_next_state = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Counter only advances while a partial frame is pending; any exit or entry clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_waiting && !i_rx_done && (r_cnt != c_timeout_last)) begin
      r_cnt <= r_cnt + NB_TIMEOUT'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_operation <= '0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && i_rx_done)    r_data_a    <= i_rx_data;
      if ((r_state == ST_WAIT_B) && i_rx_done)  r_data_b    <= i_rx_data;
      if ((r_state == ST_WAIT_OP) && i_rx_done) r_operation <= i_rx_data[NB_OP-1:0];
      if (r_state == ST_EXEC)                   r_tx_data   <= i_alu_result;
      r_tx_start <= (r_state == ST_EXEC);
      r_timeout  <= w_expire;
    end
  end

  generate
    if (NB_OP < NB_DATA) begin : g_unused_bits
      logic w_unused_rx_bits;
      assign w_unused_rx_bits = ^i_rx_data[NB_DATA-1:NB_OP];
    end
  endgenerate

  assign o_data_a    = r_data_a;
  assign o_data_b    = r_data_b;
  assign o_operation = r_operation;
  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_timeout   = r_timeout;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
